// File: rtl/wma_alarm_monitor.sv
`default_nettype none
// ============================================================================
// wma_alarm_monitor : registers the WMA calculator's inputs, commits results,
// and raises debounced high/low band alarms.  Rev 1.0
// ============================================================================
module wma_alarm_monitor #(
  parameter int unsigned DEBOUNCE    = 3,
  parameter int unsigned CLEAR_COUNT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid,
  input  logic [7:0] sample,
  output logic       sample_ready,
  input  logic [1:0] cfg_sel,
  output logic [7:0] calc_x,
  output logic [7:0] calc_wma0,
  output logic [1:0] calc_sel,
  input  logic [7:0] calc_wma1,
  input  logic [7:0] calc_t1,
  input  logic [7:0] calc_t2,
  output logic [7:0] wma_out,
  output logic [7:0] t1_out,
  output logic [7:0] t2_out,
  output logic       wma_valid,
  output logic       high_alarm,
  output logic       low_alarm,
  output logic       alarm_event
);

  localparam logic [3:0] C_DEBOUNCE = 4'(DEBOUNCE);
  localparam logic [3:0] C_CLEAR    = 4'(CLEAR_COUNT);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_READY = 2'd1,
    S_EVAL  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] calc_x_q, calc_x_d, calc_wma0_q, calc_wma0_d;
  logic [1:0] calc_sel_q, calc_sel_d;
  logic [7:0] wma_out_q, wma_out_d, t1_out_q, t1_out_d, t2_out_q, t2_out_d;
  logic       wma_valid_q, wma_valid_d;
  logic       high_alarm_q, high_alarm_d, low_alarm_q, low_alarm_d;
  logic       alarm_event_q, alarm_event_d;
  logic [3:0] hi_cnt_q, hi_cnt_d, lo_cnt_q, lo_cnt_d, ok_cnt_q, ok_cnt_d;
  logic       accept;

  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction

  assign sample_ready = !rst && (state_q != S_EVAL);
  assign accept       = sample_valid && sample_ready;

  always_comb begin
    state_d       = state_q;
    calc_x_d      = calc_x_q;
    calc_wma0_d   = calc_wma0_q;
    calc_sel_d    = calc_sel_q;
    wma_out_d     = wma_out_q;
    t1_out_d      = t1_out_q;
    t2_out_d      = t2_out_q;
    wma_valid_d   = wma_valid_q;
    high_alarm_d  = high_alarm_q;
    low_alarm_d   = low_alarm_q;
    alarm_event_d = 1'b0;
    hi_cnt_d      = hi_cnt_q;
    lo_cnt_d      = lo_cnt_q;
    ok_cnt_d      = ok_cnt_q;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          calc_wma0_d = sample;
          wma_out_d   = sample;
          t1_out_d    = sample;
          t2_out_d    = sample;
          calc_sel_d  = cfg_sel;
          wma_valid_d = 1'b1;
          state_d     = S_READY;
        end
      end
      S_READY: begin
        if (accept) begin
          calc_x_d   = sample;
          calc_sel_d = cfg_sel;
          state_d    = S_EVAL;
        end
      end
      S_EVAL: begin
        wma_out_d   = calc_wma1;
        calc_wma0_d = calc_wma1;
        t1_out_d    = calc_t1;
        t2_out_d    = calc_t2;
        if (calc_x > calc_t2) begin
          hi_cnt_d = sat_inc(hi_cnt_q);
          lo_cnt_d = 4'd0;
          ok_cnt_d = 4'd0;
        end else if (calc_x < calc_t1) begin
          lo_cnt_d = sat_inc(lo_cnt_q);
          hi_cnt_d = 4'd0;
          ok_cnt_d = 4'd0;
        end else begin
          hi_cnt_d = 4'd0;
          lo_cnt_d = 4'd0;
          ok_cnt_d = sat_inc(ok_cnt_q);
        end
        // Only one counter can be nonzero, so at most one branch fires.
        if (hi_cnt_d == C_DEBOUNCE && !high_alarm_q) begin
          high_alarm_d  = 1'b1;
          low_alarm_d   = 1'b0;
          alarm_event_d = 1'b1;
        end
        if (lo_cnt_d == C_DEBOUNCE && !low_alarm_q) begin
          low_alarm_d   = 1'b1;
          high_alarm_d  = 1'b0;
          alarm_event_d = 1'b1;
        end
        if (ok_cnt_d == C_CLEAR) begin
          high_alarm_d = 1'b0;
          low_alarm_d  = 1'b0;
        end
        state_d = S_READY;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_EMPTY;
      calc_x_q      <= 8'd0;
      calc_wma0_q   <= 8'd0;
      calc_sel_q    <= 2'd0;
      wma_out_q     <= 8'd0;
      t1_out_q      <= 8'd0;
      t2_out_q      <= 8'd0;
      wma_valid_q   <= 1'b0;
      high_alarm_q  <= 1'b0;
      low_alarm_q   <= 1'b0;
      alarm_event_q <= 1'b0;
      hi_cnt_q      <= 4'd0;
      lo_cnt_q      <= 4'd0;
      ok_cnt_q      <= 4'd0;
    end else begin
      state_q       <= state_d;
      calc_x_q      <= calc_x_d;
      calc_wma0_q   <= calc_wma0_d;
      calc_sel_q    <= calc_sel_d;
      wma_out_q     <= wma_out_d;
      t1_out_q      <= t1_out_d;
      t2_out_q      <= t2_out_d;
      wma_valid_q   <= wma_valid_d;
      high_alarm_q  <= high_alarm_d;
      low_alarm_q   <= low_alarm_d;
      alarm_event_q <= alarm_event_d;
      hi_cnt_q      <= hi_cnt_d;
      lo_cnt_q      <= lo_cnt_d;
      ok_cnt_q      <= ok_cnt_d;
    end
  end

  assign calc_x      = calc_x_q;
  assign calc_wma0   = calc_wma0_q;
  assign calc_sel    = calc_sel_q;
  assign wma_out     = wma_out_q;
  assign t1_out      = t1_out_q;
  assign t2_out      = t2_out_q;
  assign wma_valid   = wma_valid_q;
  assign high_alarm  = high_alarm_q;
  assign low_alarm   = low_alarm_q;
  assign alarm_event = alarm_event_q;

endmodule
`default_nettype wire

// File: tb/tb_wma_alarm_monitor.sv
`default_nettype none
// ============================================================================
// tb_wma_alarm_monitor : directed bench with a reference alarm model feeding
// an expected-result queue that is drained as each result commits.  Rev 1.0
// ============================================================================
module tb_wma_alarm_monitor;

  localparam int DEB = 3;
  localparam int CLR = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_valid;
  logic [7:0] sample;
  logic       sample_ready;
  logic [1:0] cfg_sel;
  logic [7:0] calc_x, calc_wma0;
  logic [1:0] calc_sel;
  logic [7:0] calc_wma1, calc_t1, calc_t2;
  logic [7:0] wma_out, t1_out, t2_out;
  logic       wma_valid, high_alarm, low_alarm, alarm_event;

  wma_alarm_monitor #(.DEBOUNCE(DEB), .CLEAR_COUNT(CLR)) dut (
    .clk(clk), .rst(rst),
    .sample_valid(sample_valid), .sample(sample), .sample_ready(sample_ready),
    .cfg_sel(cfg_sel),
    .calc_x(calc_x), .calc_wma0(calc_wma0), .calc_sel(calc_sel),
    .calc_wma1(calc_wma1), .calc_t1(calc_t1), .calc_t2(calc_t2),
    .wma_out(wma_out), .t1_out(t1_out), .t2_out(t2_out),
    .wma_valid(wma_valid), .high_alarm(high_alarm), .low_alarm(low_alarm),
    .alarm_event(alarm_event)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] wma;
    logic [7:0] t1;
    logic [7:0] t2;
    logic       high;
    logic       low;
    logic       ev;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   m_hi = 0, m_lo = 0, m_ok = 0;
  logic m_high = 1'b0, m_low = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (sample_ready !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'd0, sample_ready}, 32'd1);
  endtask

  task automatic seed(input logic [7:0] s, input logic [1:0] sel);
    wait_ready();
    sample_valid = 1'b1; sample = s; cfg_sel = sel;
    @(posedge clk);
    @(negedge clk);
    sample_valid = 1'b0;
    chk("seed_wma",   wma_out,   s);
    chk("seed_t1",    t1_out,    s);
    chk("seed_t2",    t2_out,    s);
    chk("seed_wma0",  calc_wma0, s);
    chk("seed_sel",   calc_sel,  sel);
    chk("seed_valid", wma_valid, 1);
    chk("seed_high",  high_alarm, m_high);
    chk("seed_low",   low_alarm,  m_low);
    chk("seed_ready", sample_ready, 1);
  endtask

  // Model the calculator's reply (w1/lo_t/hi_t) and the expected alarm state.
  task automatic push_expect(input logic [7:0] s, input logic [7:0] w1,
                             input logic [7:0] lo_t, input logic [7:0] hi_t);
    exp_t e;
    e.ev = 1'b0;
    if (s > hi_t) begin
      m_hi = (m_hi == 15) ? 15 : m_hi + 1; m_lo = 0; m_ok = 0;
    end else if (s < lo_t) begin
      m_lo = (m_lo == 15) ? 15 : m_lo + 1; m_hi = 0; m_ok = 0;
    end else begin
      m_ok = (m_ok == 15) ? 15 : m_ok + 1; m_hi = 0; m_lo = 0;
    end
    if (m_hi == DEB && !m_high) begin m_high = 1'b1; m_low = 1'b0; e.ev = 1'b1; end
    if (m_lo == DEB && !m_low)  begin m_low = 1'b1; m_high = 1'b0; e.ev = 1'b1; end
    if (m_ok == CLR) begin m_high = 1'b0; m_low = 1'b0; end
    e.wma = w1; e.t1 = lo_t; e.t2 = hi_t; e.high = m_high; e.low = m_low;
    sb.push_back(e);
  endtask

  task automatic accept_only(input logic [7:0] s, input logic [1:0] sel,
                             input logic [7:0] w1, input logic [7:0] lo_t,
                             input logic [7:0] hi_t);
    wait_ready();
    sample_valid = 1'b1; sample = s; cfg_sel = sel;
    calc_wma1 = w1; calc_t1 = lo_t; calc_t2 = hi_t;
    @(posedge clk);
    @(negedge clk);
    sample_valid = 1'b0;
    chk("eval_ready", sample_ready, 0);
    chk("calc_x",     calc_x,   s);
    chk("calc_sel",   calc_sel, sel);
    chk("event_idle", alarm_event, 0);
  endtask

  task automatic send(input logic [7:0] s, input logic [1:0] sel,
                      input logic [7:0] w1, input logic [7:0] lo_t,
                      input logic [7:0] hi_t);
    exp_t e;
    push_expect(s, w1, lo_t, hi_t);
    accept_only(s, sel, w1, lo_t, hi_t);
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("wma_out",    wma_out,    e.wma);
      chk("calc_wma0",  calc_wma0,  e.wma);
      chk("t1_out",     t1_out,     e.t1);
      chk("t2_out",     t2_out,     e.t2);
      chk("high_alarm", high_alarm, e.high);
      chk("low_alarm",  low_alarm,  e.low);
      chk("alarm_event", alarm_event, e.ev);
      chk("ready_back", sample_ready, 1);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_x"},     calc_x, 0);
    chk({tag, "_wma0"},  calc_wma0, 0);
    chk({tag, "_sel"},   calc_sel, 0);
    chk({tag, "_wma"},   wma_out, 0);
    chk({tag, "_t1"},    t1_out, 0);
    chk({tag, "_t2"},    t2_out, 0);
    chk({tag, "_valid"}, wma_valid, 0);
    chk({tag, "_high"},  high_alarm, 0);
    chk({tag, "_low"},   low_alarm, 0);
    chk({tag, "_event"}, alarm_event, 0);
  endtask

  initial begin
    rst = 1'b1; sample_valid = 1'b0; sample = 8'd0; cfg_sel = 2'd0;
    calc_wma1 = 8'd0; calc_t1 = 8'd0; calc_t2 = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("rst");
    chk("rst_ready", sample_ready, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", sample_ready, 1);

    // Seed, then one in-band evaluation.
    seed(8'd100, 2'd1);
    send(8'd101, 2'd1, 8'd100, 8'd97, 8'd103);

    // Three over-band samples raise high_alarm on the third.
    repeat (3) send(8'd120, 2'd2, 8'd100, 8'd97, 8'd103);

    // Two in-band samples clear it.
    repeat (2) send(8'd100, 2'd0, 8'd100, 8'd97, 8'd103);

    // Re-raise, then a lone in-band sample followed by an over-band one keeps it.
    repeat (3) send(8'd120, 2'd1, 8'd105, 8'd97, 8'd103);
    send(8'd100, 2'd1, 8'd104, 8'd97, 8'd103);
    send(8'd120, 2'd3, 8'd106, 8'd97, 8'd103);

    // Swap to low: third under-band sample raises low and drops high together.
    repeat (3) send(8'd50, 2'd2, 8'd90, 8'd97, 8'd103);

    // Band edges are inclusive.
    send(8'd97,  2'd0, 8'd97,  8'd97, 8'd103);
    send(8'd103, 2'd0, 8'd98,  8'd97, 8'd103);

    // Reset while the accepted sample is in evaluation.
    accept_only(8'd150, 2'd2, 8'd77, 8'd10, 8'd20);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("mid_rst");
    rst = 1'b0;
    m_hi = 0; m_lo = 0; m_ok = 0; m_high = 1'b0; m_low = 1'b0;
    #1;
    chk("mid_rst_ready", sample_ready, 1);
    seed(8'd55, 2'd3);
    send(8'd200, 2'd0, 8'd60, 8'd50, 8'd70);

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
